// File: rtl/multi_rate_monitor.sv
// multi_rate_monitor: N-channel event-rate monitor. Each asynchronous input is
// synchronised and edge-detected, and its edges are counted over a common gate
// window timed by clk50. At window end the counts and the range, overflow and
// stale flags are published, unless hold is set.
module multi_rate_monitor #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 50000000
) (
    input  logic                      clk50,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       ev_in,
    input  logic [CHANNELS-1:0]       both_edges,
    input  logic [CNT_W-1:0]          lo_thr,
    input  logic [CNT_W-1:0]          hi_thr,
    input  logic                      hold,
    output logic [CHANNELS*CNT_W-1:0] count_out,
    output logic                      valid,
    output logic [CHANNELS-1:0]       in_range,
    output logic [CHANNELS-1:0]       ovf,
    output logic [CHANNELS-1:0]       stale,
    output logic                      heartbeat
);

    localparam int              GW      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]   GC_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [CHANNELS-1:0] r_hist;
    logic [GW-1:0]       r_gcnt;
    logic                r_valid;
    logic                r_heartbeat;

    logic [CHANNELS-1:0] w_edge;
    logic                w_term;
    logic                w_publish;

    // Two-stage synchroniser followed by the history stage used for edge detection.
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= ev_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Rising edges always count; falling edges only where both_edges is set.
    assign w_edge    = (r_sync2 & ~r_hist) | (~r_sync2 & r_hist & both_edges);
    assign w_term    = (r_gcnt == GC_LAST);
    assign w_publish = w_term & ~hold;

    // Gate counter, wrapping at the window length; terminal cycle closes the window.
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_gcnt <= '0;
        end else if (w_term) begin
            r_gcnt <= '0;
        end else begin
            r_gcnt <= r_gcnt + 1'b1;
        end
    end

    // Publish strobe and heartbeat; heartbeat flips at every window end, held or not.
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_heartbeat <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (w_term) begin
                r_heartbeat <= ~r_heartbeat;
            end
        end
    end

    assign valid     = r_valid;
    assign heartbeat = r_heartbeat;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : gen_ch
            logic [CNT_W-1:0] r_acc;
            logic             r_sat;
            logic [CNT_W-1:0] r_count;
            logic             r_in_range;
            logic             r_ovf;
            logic             r_stale;
            logic [CNT_W-1:0] w_final;
            logic             w_final_sat;

            // Saturating count including this cycle's edge, so a terminal-cycle
            // edge lands in the closing window.
            assign w_final     = (w_edge[gi] && (r_acc != ACC_MAX)) ? r_acc + 1'b1 : r_acc;
            assign w_final_sat = r_sat | (w_final == ACC_MAX);

            // Accumulator and saturation flag, cleared at every window end.
            always_ff @(posedge clk50) begin
                if (rst || w_term) begin
                    r_acc <= '0;
                    r_sat <= 1'b0;
                end else begin
                    r_acc <= w_final;
                    r_sat <= w_final_sat;
                end
            end

            // Published results; an inverted threshold pair naturally yields 0.
            always_ff @(posedge clk50) begin
                if (rst) begin
                    r_count    <= '0;
                    r_in_range <= 1'b0;
                    r_ovf      <= 1'b0;
                    r_stale    <= 1'b0;
                end else if (w_publish) begin
                    r_count    <= w_final;
                    r_in_range <= (lo_thr <= w_final) && (w_final <= hi_thr);
                    r_ovf      <= w_final_sat;
                    r_stale    <= (w_final == '0);
                end
            end

            assign count_out[gi*CNT_W +: CNT_W] = r_count;
            assign in_range[gi]                 = r_in_range;
            assign ovf[gi]                      = r_ovf;
            assign stale[gi]                    = r_stale;
        end
    endgenerate

endmodule
